// File: rtl/rle_out_encoder.sv
// Run-length encoder for the RAM result region: reads N-bit words, scans each LSB first and
// streams {0, run value, run length} tokens under valid/ready. RLE_EOB_EN adds an 8'h80 marker.
module rle_out_encoder #(
  parameter int unsigned    N         = 32,
  parameter int unsigned    AW        = 20,
  parameter logic [AW-1:0]  BASE_ADDR = AW'(20)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] len,
  output logic          mem_rd,
  output logic [AW-1:0] mem_addr,
  input  logic [N-1:0]  mem_rdata,
  output logic [7:0]    token,
  output logic          token_valid,
  input  logic          token_ready,
  output logic          busy,
  output logic          done
);

  localparam int unsigned CW = $clog2(N) + 1;

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StFetch = 3'd1;
  localparam logic [2:0] StLoad  = 3'd2;
  localparam logic [2:0] StScan  = 3'd3;
  localparam logic [2:0] StEmit  = 3'd4;
  localparam logic [2:0] StFin   = 3'd5;
`ifdef RLE_EOB_EN
  localparam logic [2:0] StEob   = 3'd6;
`endif

  logic [2:0]    state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] len_q, len_d;
  logic [AW-1:0] word_cnt_q, word_cnt_d;
  logic [N-1:0]  sr_q, sr_d;
  logic          run_val_q, run_val_d;
  logic [CW-1:0] run_cnt_q, run_cnt_d;
  logic [CW-1:0] ptr_q, ptr_d;
  logic          last_q, last_d;
  logic [7:0]    token_q, token_d;

  logic [CW-1:0] run_cnt_inc;
  logic [AW-1:0] words_done;

  assign run_cnt_inc = run_cnt_q + CW'(1);
  assign words_done  = word_cnt_q + AW'(1);

  function automatic logic [7:0] make_token(input logic val, input logic [CW-1:0] cnt);
    logic [7:0] t;
    t         = '0;
    t[6]      = val;
    t[CW-1:0] = cnt;
    return t;
  endfunction

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    word_cnt_d = word_cnt_q;
    sr_d       = sr_q;
    run_val_d  = run_val_q;
    run_cnt_d  = run_cnt_q;
    ptr_d      = ptr_q;
    last_d     = last_q;
    token_d    = token_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          if (len == '0) begin
`ifdef RLE_EOB_EN
            token_d = 8'h80;
            state_d = StEob;
`else
            state_d = StFin;
`endif
          end else begin
            len_d      = len;
            addr_d     = BASE_ADDR;
            word_cnt_d = '0;
            state_d    = StFetch;
          end
        end
      end

      StFetch: state_d = StLoad;

      StLoad: begin
        // Bit 0 seeds the first run, so the shift register starts one bit ahead.
        sr_d      = mem_rdata >> 1;
        run_val_d = mem_rdata[0];
        run_cnt_d = CW'(1);
        ptr_d     = CW'(1);
        last_d    = 1'b0;
        state_d   = StScan;
      end

      StScan: begin
        if (ptr_q == CW'(N)) begin
          // Last bit opened a fresh run of one; flush it as the word's final token.
          token_d = make_token(run_val_q, run_cnt_q);
          last_d  = 1'b1;
          state_d = StEmit;
        end else begin
          sr_d  = sr_q >> 1;
          ptr_d = ptr_q + CW'(1);
          if (sr_q[0] == run_val_q) begin
            run_cnt_d = run_cnt_inc;
            if (ptr_q == CW'(N - 1)) begin
              token_d = make_token(run_val_q, run_cnt_inc);
              last_d  = 1'b1;
              state_d = StEmit;
            end
          end else begin
            token_d   = make_token(run_val_q, run_cnt_q);
            run_val_d = sr_q[0];
            run_cnt_d = CW'(1);
            state_d   = StEmit;
          end
        end
      end

      StEmit: begin
        if (token_ready) begin
          if (!last_q) begin
            state_d = StScan;
          end else if (words_done == len_q) begin
`ifdef RLE_EOB_EN
            token_d = 8'h80;
            state_d = StEob;
`else
            state_d = StFin;
`endif
          end else begin
            word_cnt_d = words_done;
            addr_d     = addr_q + AW'(1);
            state_d    = StFetch;
          end
        end
      end

`ifdef RLE_EOB_EN
      StEob: begin
        if (token_ready) state_d = StFin;
      end
`endif

      StFin: state_d = StIdle;

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      addr_q     <= BASE_ADDR;
      len_q      <= '0;
      word_cnt_q <= '0;
      sr_q       <= '0;
      run_val_q  <= 1'b0;
      run_cnt_q  <= '0;
      ptr_q      <= '0;
      last_q     <= 1'b0;
      token_q    <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      word_cnt_q <= word_cnt_d;
      sr_q       <= sr_d;
      run_val_q  <= run_val_d;
      run_cnt_q  <= run_cnt_d;
      ptr_q      <= ptr_d;
      last_q     <= last_d;
      token_q    <= token_d;
    end
  end

  assign mem_rd      = (state_q == StFetch);
  assign mem_addr    = addr_q;
  assign token       = token_q;
`ifdef RLE_EOB_EN
  assign token_valid = (state_q == StEmit) || (state_q == StEob);
`else
  assign token_valid = (state_q == StEmit);
`endif
  assign busy        = (state_q != StIdle);
  assign done        = (state_q == StFin);

  a_token_hold: assert property (@(posedge clk) disable iff (reset)
      (token_valid && !token_ready) |=> (token_valid && $stable(token)));

endmodule

// File: tb/tb_rle_out_encoder.sv
// Bench for rle_out_encoder: a RAM model plus a bit-scanning reference that builds the expected
// token stream per block; directed cases then randomized words and backpressure.
module tb_rle_out_encoder;

  localparam int unsigned   N    = 32;
  localparam int unsigned   AW   = 20;
  localparam logic [AW-1:0] BASE = AW'(20);

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] len;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic [N-1:0]  mem_rdata;
  logic [7:0]    token;
  logic          token_valid;
  logic          token_ready;
  logic          busy;
  logic          done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem_arr [8];
  logic [7:0]  exp_q [$];

  always #5 clk = ~clk;

  rle_out_encoder #(.N(N), .AW(AW), .BASE_ADDR(BASE)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .len         (len),
    .mem_rd      (mem_rd),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .token       (token),
    .token_valid (token_valid),
    .token_ready (token_ready),
    .busy        (busy),
    .done        (done)
  );

  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= mem_arr[3'(mem_addr - BASE)];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: walk the word bit by bit, closing a run whenever the bit value changes.
  task automatic model_word(input logic [31:0] w);
    logic v;
    int   c;
    v = w[0];
    c = 1;
    for (int b = 1; b < 32; b++) begin
      if (w[b] == v) c++;
      else begin
        exp_q.push_back(8'((v ? 64 : 0) + c));
        v = w[b];
        c = 1;
      end
    end
    exp_q.push_back(8'((v ? 64 : 0) + c));
  endtask

  task automatic run_block(input int nw, input bit bp, input string name);
    int   reads  = 0;
    int   hs     = 0;
    int   last_hs = -10;
    int   cyc    = 0;
    int   n_tok;
    bit   finished = 0;
    bit   stall  = 0;
    logic [7:0] held = '0;
    exp_q.delete();
    for (int i = 0; i < nw; i++) model_word(mem_arr[i]);
`ifdef RLE_EOB_EN
    exp_q.push_back(8'h80);
`endif
    n_tok = exp_q.size();
    @(negedge clk);
    start = 1'b1;
    len   = AW'(nw);
    token_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    len   = AW'($urandom_range(0, 7));
    check_eq({name, " busy"}, busy, 1);
    while (!finished && cyc < 5000) begin
      if (stall) begin
        check_eq({name, " valid_hold"}, token_valid, 1);
        check_eq({name, " token_hold"}, token, held);
      end
      token_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (mem_rd) begin
        check_eq({name, " addr"}, mem_addr, 32'(BASE) + reads);
        reads++;
      end
      if (token_valid && token_ready) begin
        if (exp_q.size() == 0) check_eq({name, " extra_token"}, hs + 1, n_tok);
        else check_eq({name, " token"}, token, exp_q.pop_front());
        hs++;
        last_hs = cyc;
      end
      stall = token_valid && !token_ready;
      held  = token;
      if (done) begin
        finished = 1;
        if (n_tok > 0) check_eq({name, " done_latency"}, cyc - last_hs, 1);
        else check_eq({name, " done_quick"}, cyc <= 1, 1);
        check_eq({name, " tokens"}, hs, n_tok);
        check_eq({name, " reads"}, reads, nw);
      end
      @(negedge clk);
      cyc++;
    end
    if (!finished) check_eq({name, " timeout"}, 0, 1);
    else begin
      check_eq({name, " done_pulse"}, done, 0);
      check_eq({name, " idle"}, busy, 0);
    end
    token_ready = 1'b0;
  endtask

  task automatic reset_mid_emit();
    int reads = 0;
    int cyc   = 0;
    mem_arr[0] = $urandom;
    mem_arr[1] = 32'h0F0F_3C3C;
    mem_arr[2] = $urandom;
    @(negedge clk);
    start = 1'b1;
    len   = AW'(3);
    @(negedge clk);
    start = 1'b0;
    token_ready = 1'b1;
    while (cyc < 2000 && !(reads == 2 && token_valid)) begin
      if (mem_rd) reads++;
      token_ready = (reads < 2);
      @(negedge clk);
      cyc++;
    end
    check_eq("rst_reached_emit", token_valid, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rst_valid", token_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_addr", mem_addr, 32'(BASE));
    check_eq("rst_done", done, 0);
    @(negedge clk);
    reset = 1'b0;
    token_ready = 1'b0;
    mem_arr[0] = 32'h8000_0001;
    mem_arr[1] = 32'h0000_FFFF;
    mem_arr[2] = 32'hFFFF_FFFE;
    run_block(3, 0, "after_rst");
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    len   = '0;
    token_ready = 1'b0;
    for (int i = 0; i < 8; i++) mem_arr[i] = '0;
    repeat (3) @(negedge clk);
    check_eq("reset_valid", token_valid, 0);
    check_eq("reset_token", token, 0);
    check_eq("reset_busy", busy, 0);
    check_eq("reset_done", done, 0);
    check_eq("reset_rd", mem_rd, 0);
    check_eq("reset_addr", mem_addr, 32'(BASE));
    reset = 1'b0;

    mem_arr[0] = 32'h0000_FFFF;
    run_block(1, 0, "half");
    mem_arr[0] = 32'hFFFF_FFFF;
    mem_arr[1] = 32'h0000_0000;
    run_block(2, 0, "solid");
    mem_arr[0] = 32'h5555_5555;
    run_block(1, 0, "alt");
    mem_arr[0] = 32'h0000_FFFF;
    run_block(1, 1, "half_bp");
    run_block(0, 0, "empty");
    run_block(0, 1, "empty_bp");

    for (int t = 0; t < 24; t++) begin
      int nw;
      nw = $urandom_range(1, 5);
      for (int i = 0; i < nw; i++) begin
        case ($urandom_range(0, 3))
          0:       mem_arr[i] = $urandom;
          1:       mem_arr[i] = $urandom & $urandom & $urandom;
          2:       mem_arr[i] = $urandom | $urandom | $urandom;
          default: mem_arr[i] = {$urandom_range(0, 1) ? 16'hFFFF : 16'h0000, 16'($urandom)};
        endcase
      end
      run_block(nw, 1'($urandom_range(0, 1)), "rand");
    end

    reset_mid_emit();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rle_out_encoder.md
Name: rle_out_encoder

Overview:
- Output-direction counterpart of the input decompression path. Reads N-bit result words from the RAM output region and run-length encodes each one.
- Streams 8-bit tokens to the CPU side under a valid/ready handshake.
- Token format matches what the decomp2 decompressors consume: bit6 = run bit value, bits[$clog2(N):0] = run length.
- Sits between the RAM read port and the CPU output bus.

Parameters:
- N, 32, data word width (power of 2, 8..32).
- AW, 20, RAM address width.
- BASE_ADDR, 20, first word address of the result (X) region.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high
- start  input  1  one-cycle pulse; begins a block, sampled only in IDLE
- len  input  AW  number of words to encode; sampled with start
- mem_rd  output  1  RAM read strobe
- mem_addr  output  AW  RAM read address
- mem_rdata  input  N  RAM read data, valid exactly 1 cycle after mem_rd
- token  output  8  encoded token
- token_valid  output  1  token holds a valid value
- token_ready  input  1  consumer accepts token when high with token_valid
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse when the block completes

Behaviour:
- Reset: state IDLE; mem_rd=0, mem_addr=BASE_ADDR, token=0, token_valid=0, busy=0, done=0; word counter and bit pointer cleared. Reset mid-operation aborts immediately; any pending token is dropped.
- Token: bit7=0; bit6=run value; bits[CW-1:0]=run length 1..N, where CW=$clog2(N)+1; remaining bits 0.
- Runs never cross word boundaries. Each word is scanned LSB first, and the run lengths of one word sum to exactly N.
- States and transitions:
  - IDLE: on start with len==0, go to FIN. On start with len!=0, latch len, set addr=BASE_ADDR, go to FETCH.
  - FETCH (1 cycle): mem_rd=1 with mem_addr=current addr, go to LOAD.
  - LOAD (1 cycle): capture mem_rdata into the shift register, run value=bit0, run count=1, bit pointer=1, go to SCAN.
  - SCAN: consume one bit per cycle.
    - Bit equals run value: count+1.
    - Bit differs: form a token for the current run, start a new run (value=bit, count=1), go to EMIT.
    - After bit N-1 is consumed: form the final token, go to EMIT with a last-of-word flag.
  - EMIT: token_valid=1, token stable until token_ready. On the handshake:
    - Not last-of-word: return to SCAN.
    - Last-of-word with words remaining: addr+1, go to FETCH.
    - Last word: go to FIN (or EOB when the feature is enabled).
  - FIN: done=1 for one cycle, go to IDLE.
- Backpressure: scanning stalls while a token is pending. token_valid never drops without a handshake, and token never changes while valid and not ready.
- start while busy is ignored. len is not re-sampled mid-block.
- mem_addr wraps modulo 2^AW.
- Throughput: one bit per cycle plus 2 cycles of fetch per word plus 1 cycle per accepted token with token_ready held high.

Optional Feature:
- Macro: RLE_EOB_EN.
- Defined: after the last word's final token is accepted, enter state EOB. EOB drives token=8'h80 with token_valid=1 and holds until token_ready, then goes to FIN. With len==0, the EOB token is still sent before done.
- Undefined: no EOB state; the last word goes directly to FIN and no marker token is emitted.

Test Plan:
- len=1, word 32'h0000FFFF, token_ready=1 -> tokens 8'h50 then 8'h10; done pulse 1 cycle after the 2nd handshake; mem_addr=20.
- len=2, words 32'hFFFFFFFF, 32'h00000000 -> tokens 8'h60, 8'h20; second read at mem_addr=21; exactly 2 mem_rd pulses.
- len=1, word 32'h55555555 -> 32 tokens alternating 8'h41, 8'h01; each token length field =1.
- Backpressure: word 32'h0000FFFF with token_ready toggled randomly -> identical token sequence; token stable while valid&&!ready; no token lost or duplicated.
- len=0 -> no mem_rd; done pulse within 2 cycles; with RLE_EOB_EN, a single 8'h80 token precedes done.
- Assert reset during EMIT of a 3-word block -> next cycle token_valid=0, busy=0, mem_addr=BASE_ADDR; a fresh start encodes correctly from word 0.
